// File: rtl/my_ram_512_bist.sv
// -----------------------------------------------------------------------------
// my_ram_512_bist
//
// Built-in self-test controller for a my_ram_512 port. Drives the RAM
// initiator signals (ram_addr, ram_in, ram_load) and checks ram_out with a
// March C- sequence over every word:
//
//   E0: up,   W D0
//   E1: up,   R D0, W D1
//   E2: up,   R D1, W D0
//   E3: down, R D0, W D1
//   E4: down, R D1, W D0
//   E5: up,   R D0
//
// with D0 = PATTERN and D1 = ~PATTERN. The first mismatch aborts the run and
// records the failing address and the word that was read.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a run; accepted only in IDLE or DONE
//   busy       out  test in progress
//   done       out  test finished; held until the next accepted start
//   fail       out  valid with done; 1 = mismatch detected
//   fail_addr  out  address of the first mismatch (0 if none)
//   fail_data  out  word read at the first mismatch (0 if none)
//   ram_addr   out  RAM address
//   ram_in     out  RAM write data (0 outside write cycles)
//   ram_load   out  RAM write enable; the write commits at the closing edge
//   ram_out    in   RAM read data, combinational from ram_addr
//
// All outputs are decoded from registered state only (Moore machine).
// -----------------------------------------------------------------------------
module my_ram_512_bist #(
  parameter int unsigned        ADDR_W  = 9,
  parameter int unsigned        DATA_W  = 16,
  parameter logic [DATA_W-1:0]  PATTERN = 16'h5555
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ONLY = 3'd1,
    RD      = 3'd2,
    WR      = 3'd3,
    RD_ONLY = 3'd4,
    DONE    = 3'd5
  } state_t;

  // March element index, 0..5 for E0..E5.
  typedef logic [2:0] elem_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] D0       = PATTERN;
  localparam logic [DATA_W-1:0] D1       = ~PATTERN;
  localparam elem_t             E0       = 3'd0;
  localparam elem_t             E1       = 3'd1;
  localparam elem_t             E2       = 3'd2;
  localparam elem_t             E3       = 3'd3;
  localparam elem_t             E4       = 3'd4;
  localparam elem_t             E5       = 3'd5;

  // Registered state
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  elem_t               r_elem;
  logic                r_fail;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_data;

  // Next-state values
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  elem_t               w_elem_nxt;
  logic                w_fail_nxt;
  logic [ADDR_W-1:0]   w_fail_addr_nxt;
  logic [DATA_W-1:0]   w_fail_data_nxt;

  // Per-element decode
  logic [DATA_W-1:0]   w_rd_exp;    // value the current element expects to read
  logic [DATA_W-1:0]   w_wr_val;    // value the current element writes
  logic                w_down;      // element walks 511 -> 0
  logic                w_last;      // address is the element's terminal value
  logic [ADDR_W-1:0]   w_addr_step; // next address within the element
  logic                w_miscmp;    // read data differs from expectation
  logic [ADDR_W-1:0]   w_reload;    // start address of the following element

  // ---------------------------------------------------------------------------
  // Element decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through
  // the case statements leaves a value unassigned (which would infer a latch).
  always_comb begin
    w_rd_exp = D0;
    w_wr_val = D0;
    w_down   = 1'b0;
    unique case (r_elem)
      E0:      begin w_rd_exp = D0; w_wr_val = D0; end
      E1:      begin w_rd_exp = D0; w_wr_val = D1; end
      E2:      begin w_rd_exp = D1; w_wr_val = D0; end
      E3:      begin w_rd_exp = D0; w_wr_val = D1; w_down = 1'b1; end
      E4:      begin w_rd_exp = D1; w_wr_val = D0; w_down = 1'b1; end
      E5:      begin w_rd_exp = D0; w_wr_val = D0; end
      default: begin w_rd_exp = D0; w_wr_val = D0; end
    endcase

    w_last      = w_down ? (r_addr == '0) : (r_addr == ADDR_MAX);
    w_addr_step = w_down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
    w_miscmp    = (ram_out != w_rd_exp);

    // Leaving E2 or E3 enters a down element (E3/E4) at the top address;
    // every other transition enters an up element at address 0.
    w_reload    = ((r_elem == E2) || (r_elem == E3)) ? ADDR_MAX : '0;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_elem_nxt      = r_elem;
    w_fail_nxt      = r_fail;
    w_fail_addr_nxt = r_fail_addr;
    w_fail_data_nxt = r_fail_data;

    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt     = WR_ONLY;
          w_addr_nxt      = '0;
          w_elem_nxt      = E0;
          w_fail_nxt      = 1'b0;
          w_fail_addr_nxt = '0;
          w_fail_data_nxt = '0;
        end
      end

      WR_ONLY: begin
        if (w_last) begin
          w_state_nxt = RD;
          w_elem_nxt  = E1;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt  = w_addr_step;
        end
      end

      RD: begin
        if (w_miscmp) begin
          w_state_nxt     = DONE;
          w_fail_nxt      = 1'b1;
          w_fail_addr_nxt = r_addr;
          w_fail_data_nxt = ram_out;
        end else begin
          w_state_nxt     = WR;
        end
      end

      WR: begin
        if (!w_last) begin
          w_state_nxt = RD;
          w_addr_nxt  = w_addr_step;
        end else if (r_elem == E4) begin
          w_state_nxt = RD_ONLY;
          w_elem_nxt  = E5;
          w_addr_nxt  = '0;
        end else begin
          w_state_nxt = RD;
          w_elem_nxt  = r_elem + 3'd1;
          w_addr_nxt  = w_reload;
        end
      end

      RD_ONLY: begin
        if (w_miscmp) begin
          w_state_nxt     = DONE;
          w_fail_nxt      = 1'b1;
          w_fail_addr_nxt = r_addr;
          w_fail_data_nxt = ram_out;
        end else if (w_last) begin
          w_state_nxt     = DONE;
        end else begin
          w_addr_nxt      = w_addr_step;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
        w_elem_nxt  = E0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_elem      <= E0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_elem      <= w_elem_nxt;
      r_fail      <= w_fail_nxt;
      r_fail_addr <= w_fail_addr_nxt;
      r_fail_data <= w_fail_data_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  logic w_is_write;
  logic w_is_active;

  assign w_is_write  = (r_state == WR_ONLY) || (r_state == WR);
  assign w_is_active = (r_state == WR_ONLY) || (r_state == RD) ||
                       (r_state == WR)      || (r_state == RD_ONLY);

  assign busy      = w_is_active;
  assign done      = (r_state == DONE);
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign ram_addr  = w_is_active ? r_addr : '0;
  assign ram_load  = w_is_write;
  assign ram_in    = w_is_write ? w_wr_val : '0;

endmodule

// File: tb/tb_my_ram_512_bist.sv
// -----------------------------------------------------------------------------
// tb_my_ram_512_bist
//
// Directed bench for my_ram_512_bist with a behavioural 512x16 RAM that can
// force bit 3 of word 9'h1A7 to 1 (stuck-at-1 fault).
// -----------------------------------------------------------------------------
module tb_my_ram_512_bist;

  localparam int BUDGET = 6000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        fail;
  logic [8:0]  fail_addr;
  logic [15:0] fail_data;
  logic [8:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] mem [512];
  logic        fault_en;

  int n_vec;
  int n_miss;

  my_ram_512_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram_addr  (ram_addr),
    .ram_in    (ram_in),
    .ram_load  (ram_load),
    .ram_out   (ram_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: synchronous write, combinational read, optional stuck-at-1.
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
  end

  assign ram_out = mem[ram_addr] |
                   ((fault_en && (ram_addr == 9'h1A7)) ? 16'h0008 : 16'h0000);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then follow the run cycle by cycle.
  // cyc is the 1-indexed busy cycle being observed.
  task automatic run(input int restart_at, input int reset_at, input bit probe,
                     output int busy_n, output int last_load);
    int          cyc;
    bit          aborted;
    logic [31:0] exp;
    busy_n    = 0;
    last_load = 0;
    aborted   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_done_fail_busy", {29'd0, busy, done, fail}, 32'h4);
    cyc = 1;
    while (busy && !aborted && cyc <= BUDGET) begin
      busy_n++;
      if (ram_load) last_load = cyc;
      if (probe) begin
        exp = 32'hFFFF_FFFF;
        case (cyc)
          1:    exp = {6'd0, 9'h000, 1'b1, 16'h5555};
          512:  exp = {6'd0, 9'h1FF, 1'b1, 16'h5555};
          513:  exp = {6'd0, 9'h000, 1'b0, 16'h0000};
          514:  exp = {6'd0, 9'h000, 1'b1, 16'hAAAA};
          1537: exp = {6'd0, 9'h000, 1'b0, 16'h0000};
          1538: exp = {6'd0, 9'h000, 1'b1, 16'h5555};
          2561: exp = {6'd0, 9'h1FF, 1'b0, 16'h0000};
          2562: exp = {6'd0, 9'h1FF, 1'b1, 16'hAAAA};
          3585: exp = {6'd0, 9'h1FF, 1'b0, 16'h0000};
          3586: exp = {6'd0, 9'h1FF, 1'b1, 16'h5555};
          4608: exp = {6'd0, 9'h000, 1'b1, 16'h5555};
          4609: exp = {6'd0, 9'h000, 1'b0, 16'h0000};
          5120: exp = {6'd0, 9'h1FF, 1'b0, 16'h0000};
          default: ;
        endcase
        if (exp != 32'hFFFF_FFFF)
          check($sformatf("probe_c%0d_addr_load_in", cyc),
                {6'd0, ram_addr, ram_load, ram_in}, exp);
      end
      if (cyc == restart_at) start = 1'b1;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_run_outputs",
              {busy, done, fail, ram_load, ram_addr, ram_in}, 32'd0);
        tick();
        tick();
        rst_n   = 1'b1;
        aborted = 1'b1;
      end else begin
        tick();
        start = 1'b0;
        cyc++;
      end
    end
    check("run_within_budget", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int busy_n;
    int last_load;
    int bad_words;
    int loads_after;

    n_vec    = 0;
    n_miss   = 0;
    fault_en = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b0;

    // Reset held for three cycles, then ten idle cycles.
    #1;
    check("reset_outputs",
          {busy, done, fail, ram_load, ram_addr, ram_in}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_c%0d_outputs", i),
            {busy, done, fail, ram_load, ram_addr, ram_in}, 32'd0);
      check($sformatf("idle_c%0d_fail_info", i), {7'd0, fail_addr, fail_data}, 32'd0);
    end

    // Clean run with a start pulse at busy cycle 100 (must be ignored).
    run(100, 0, 1'b1, busy_n, last_load);
    check("clean_busy_cycles", busy_n, 32'd5120);
    check("clean_done_fail", {30'd0, done, fail}, 32'h2);
    check("clean_fail_info", {7'd0, fail_addr, fail_data}, 32'd0);
    bad_words = 0;
    for (int a = 0; a < 512; a++) if (mem[a] !== 16'h5555) bad_words++;
    check("clean_readback_bad_words", bad_words, 32'd0);
    repeat (3) tick();
    check("clean_done_held", {30'd0, busy, done}, 32'h1);

    // Reset at busy cycle 2000, then a full pass.
    run(0, 2000, 1'b0, busy_n, last_load);
    check("reset_busy_cycles_before_abort", busy_n, 32'd2000);
    tick();
    check("after_reset_idle", {busy, done, fail, ram_load, ram_addr, ram_in}, 32'd0);
    run(0, 0, 1'b0, busy_n, last_load);
    check("post_reset_busy_cycles", busy_n, 32'd5120);
    check("post_reset_done_fail", {30'd0, done, fail}, 32'h2);

    // Stuck-at-1 on bit 3 of word 9'h1A7: caught at the E1 read, busy cycle 1359.
    fault_en = 1'b1;
    run(0, 0, 1'b0, busy_n, last_load);
    check("stuck_busy_cycles", busy_n, 32'd1359);
    check("stuck_last_write_cycle", last_load, 32'd1358);
    check("stuck_done_fail", {30'd0, done, fail}, 32'h3);
    check("stuck_fail_addr", {23'd0, fail_addr}, 32'h1A7);
    check("stuck_fail_data", {16'd0, fail_data}, 32'h555D);
    loads_after = 0;
    for (int i = 0; i < 20; i++) begin
      if (ram_load) loads_after++;
      tick();
    end
    check("stuck_no_writes_after_fail", loads_after, 32'd0);
    check("stuck_result_held", {30'd0, done, fail}, 32'h3);

    // Restart after fail with the fault removed.
    fault_en = 1'b0;
    run(0, 0, 1'b1, busy_n, last_load);
    check("restart_busy_cycles", busy_n, 32'd5120);
    check("restart_done_fail", {30'd0, done, fail}, 32'h2);
    check("restart_fail_info", {7'd0, fail_addr, fail_data}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
